// File: rtl/pin_stretch_pkg.sv
// pin_stretch_pkg: shared state encoding and default pulse timing matching the key debouncer window
package pin_stretch_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, HIGH = ST_HIGH, GAP = ST_GAP} state_t;
  localparam int DEF_HIGH_CYC = 240000;
  localparam int DEF_GAP_CYC  = 240000;
endpackage

// File: rtl/pin_stretch_pend.sv
// pend_counter: saturating up/down request counter with sticky overflow flag
module pend_counter #(
  parameter int MAX = 3,
  parameter int W   = 2
)(
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr_ovf,
  output logic [W-1:0] cnt,
  output logic         ovf
);
  logic full;
  assign full = cnt == W'(MAX);
  // simultaneous inc/dec nets out; an increment into a full counter is dropped and flagged
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= (inc && !dec && !full) ? cnt + 1'b1 : (dec && !inc) ? cnt - 1'b1 : cnt;
      ovf <= (inc && !dec && full) || (ovf && !clr_ovf);
    end
endmodule

// File: rtl/pin_stretch.sv
// pin_stretch: stretches request pulses to HIGH_CYC high / GAP_CYC low on a pin; request queue enabled by PIN_STRETCH_QUEUE_EN
module pin_stretch
  import pin_stretch_pkg::*;
#(
  parameter int HIGH_CYC = DEF_HIGH_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int BITS     = 20,
  parameter int MAX_PEND = 3,
  parameter int PBITS    = 2
)(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             req_i,
  input  logic             clr_ovf_i,
  output logic             pin_o,
  output logic             busy_o,
  output logic [PBITS-1:0] pend_o,
  output logic             ovf_o
);
  state_t state, state_n;
  logic [BITS-1:0] cnt;
  logic hi_done, gap_done, busy, restart;
  if (MAX_PEND < 1 || MAX_PEND >= (1 << PBITS)) begin : g_bad_pend
    $error("pin_stretch: PBITS cannot hold MAX_PEND");
  end
  assign busy     = state != IDLE;
  assign hi_done  = state == HIGH && cnt == BITS'(HIGH_CYC - 1);
  assign gap_done = state == GAP && cnt == BITS'(GAP_CYC - 1);
`ifdef PIN_STRETCH_QUEUE_EN
  logic pend_nz;
  assign pend_nz = pend_o != '0;
  assign restart = pend_nz || req_i;
  pend_counter #(.MAX(MAX_PEND), .W(PBITS)) u_pend (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .inc     (req_i && busy && !(gap_done && !pend_nz)),
    .dec     (gap_done && pend_nz),
    .clr_ovf (clr_ovf_i),
    .cnt     (pend_o),
    .ovf     (ovf_o)
  );
`else
  assign restart = 1'b0;
  assign pend_o  = '0;
  // without a queue every request seen while busy is lost
  always_ff @(posedge sys_clk)
    if (sys_rst) ovf_o <= 1'b0;
    else ovf_o <= (req_i && busy) || (ovf_o && !clr_ovf_i);
`endif
  // next state: idle waits for a request, high and gap run their hold windows
  always_comb begin
    state_n = state == IDLE ? (req_i ? HIGH : IDLE) :
              state == HIGH ? (hi_done ? GAP : HIGH) :
              gap_done ? (restart ? HIGH : IDLE) : GAP;
  end
  // state, hold counter (cleared on every state entry) and registered pin drive
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      pin_o  <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      pin_o  <= state_n == HIGH;
      busy_o <= state_n != IDLE;
    end
endmodule

// File: tb/tb_pin_stretch.sv
// tb_pin_stretch: time-based pulse schedule model plus directed and random stimulus
module tb_pin_stretch;
  localparam int H = 4, G = 3, MAXP = 2;
`ifdef PIN_STRETCH_QUEUE_EN
  localparam bit Q = 1'b1;
`else
  localparam bit Q = 1'b0;
`endif
  logic sys_clk = 1'b0, sys_rst = 1'b1, req_i = 1'b0, clr_ovf_i = 1'b0;
  logic pin_o, busy_o, ovf_o;
  logic [1:0] pend_o;
  int tot = 0, bad = 0, np = 0, gap = 0, last = 0, ncyc = 0;
  bit prev_pin = 1'b0;
  int e = 0, s = -1000, c = -1000, pend = 0;
  bit m_ovf = 1'b0, m_pin = 1'b0, m_busy = 1'b0, live = 1'b0;
  always #5 sys_clk = ~sys_clk;
  pin_stretch #(.HIGH_CYC(H), .GAP_CYC(G), .BITS(3), .MAX_PEND(MAXP), .PBITS(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_i(req_i), .clr_ovf_i(clr_ovf_i),
    .pin_o(pin_o), .busy_o(busy_o), .pend_o(pend_o), .ovf_o(ovf_o)
  );
  // model: a pulse started at edge s is high after edges s..s+H-1 and completes at edge c=s+H+G
  always @(posedge sys_clk) begin
    bit so;
    so = 1'b0;
    e++;
    if (sys_rst) begin
      s = -1000; c = -1000; pend = 0; m_ovf = 1'b0; live = 1'b1;
    end else begin
      if (e < c) begin
        if (req_i) begin
          if (Q && pend < MAXP) pend++;
          else so = 1'b1;
        end
      end else if (e == c && !Q) so = req_i;
      else if (pend > 0) begin
        s = e; c = e + H + G;
        if (!req_i) pend--;
      end else if (req_i) begin
        s = e; c = e + H + G;
      end
      m_ovf = so | (m_ovf & !clr_ovf_i);
    end
    m_pin  = e >= s && e < s + H;
    m_busy = e < c;
  end
  task automatic cyc(input bit r = 1'b0, input bit cl = 1'b0, input bit rs = 1'b0);
    req_i = r; clr_ovf_i = cl; sys_rst = rs;
    @(negedge sys_clk);
    req_i = 1'b0; clr_ovf_i = 1'b0; sys_rst = 1'b0;
    if (live) begin
      tot++;
      if ({pin_o, busy_o, pend_o, ovf_o} !== {m_pin, m_busy, 2'(pend), m_ovf}) begin
        bad++;
        $display("FAIL model cyc=%0d pin/busy/pend/ovf got %b/%b/%0d/%b want %b/%b/%0d/%b",
                 ncyc, pin_o, busy_o, pend_o, ovf_o, m_pin, m_busy, pend, m_ovf);
      end
    end
    if (pin_o && !prev_pin) begin
      np++; gap = ncyc - last; last = ncyc;
    end
    prev_pin = pin_o;
    ncyc++;
  endtask
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask
  initial begin
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk("rst_pin", 8'(pin_o), 0); chk("rst_busy", 8'(busy_o), 0);
    chk("rst_pend", 8'(pend_o), 0); chk("rst_ovf", 8'(ovf_o), 0);
    np = 0;
    cyc(1); chk("s1_pin_rise", 8'(pin_o), 1); chk("s1_busy_rise", 8'(busy_o), 1);
    repeat (3) cyc();
    chk("s1_pin_last", 8'(pin_o), 1);
    cyc(); chk("s1_pin_fall", 8'(pin_o), 0); chk("s1_busy_gap", 8'(busy_o), 1);
    repeat (2) cyc();
    chk("s1_busy_hold", 8'(busy_o), 1);
    cyc(); chk("s1_busy_fall", 8'(busy_o), 0); chk("s1_pend", 8'(pend_o), 0); chk("s1_np", 8'(np), 1);
`ifdef PIN_STRETCH_QUEUE_EN
    np = 0;
    cyc(1); cyc(1); chk("s2_pend1", 8'(pend_o), 1);
    cyc(1); chk("s2_pend2", 8'(pend_o), 2); chk("s2_ovf0", 8'(ovf_o), 0);
    cyc(1); chk("s2_ovf_set", 8'(ovf_o), 1); chk("s2_pend_sat", 8'(pend_o), 2);
    repeat (25) cyc();
    chk("s2_np", 8'(np), 3); chk("s2_period", 8'(gap), 7);
    cyc(0, 1); chk("s2_ovf_clr", 8'(ovf_o), 0);
    np = 0;
    cyc(1); cyc(1); chk("s3_pend1", 8'(pend_o), 1);
    repeat (5) cyc();
    cyc(1); chk("s3_pin_restart", 8'(pin_o), 1); chk("s3_pend_kept", 8'(pend_o), 1);
    repeat (20) cyc();
    chk("s3_np", 8'(np), 3);
`else
    np = 0;
    cyc(1); cyc(); cyc(1);
    chk("s2_ovf_set", 8'(ovf_o), 1); chk("s2_pend0", 8'(pend_o), 0);
    repeat (20) cyc();
    chk("s2_np", 8'(np), 1);
    cyc(0, 1); chk("s2_ovf_clr", 8'(ovf_o), 0);
    np = 0;
    cyc(1);
    repeat (6) cyc();
    cyc(1); chk("s3_pin", 8'(pin_o), 0); chk("s3_busy", 8'(busy_o), 0); chk("s3_ovf", 8'(ovf_o), 1);
    repeat (8) cyc();
    chk("s3_np", 8'(np), 1);
    cyc(0, 1);
`endif
    cyc(1); cyc(1); cyc(1); cyc();
    cyc(0, 0, 1);
    chk("s4_pin", 8'(pin_o), 0); chk("s4_busy", 8'(busy_o), 0);
    chk("s4_pend", 8'(pend_o), 0); chk("s4_ovf", 8'(ovf_o), 0);
    np = 0;
    repeat (20) cyc();
    chk("s4_np", 8'(np), 0);
    repeat (1500)
      cyc($urandom_range(0, 9) < 4, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
